// File: rtl/gray_to_binary_tracker.sv
// Two-stage Gray-to-binary decoder that classifies each decoded sample against the
// previous one (step up/down, hold, illegal jump) and counts illegal jumps.
module gray_to_binary_tracker #(
   parameter int WIDTH = 4,
   parameter int ERR_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] gray_in,
   input  logic             in_valid,
   input  logic             err_clr,
   output logic [WIDTH-1:0] bin_out,
   output logic             out_valid,
   output logic             step_up,
   output logic             step_down,
   output logic             jump_err,
   output logic             locked,
   output logic [ERR_W-1:0] err_count
);

   localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

   logic [1:0]       vld_pipe;
   logic [WIDTH-1:0] g_q;
   logic [WIDTH-1:0] bin_dec;
   logic [WIDTH-1:0] delta;
   logic             is_up, is_dn, is_jump;

   // Each binary bit is the XOR of its Gray bit and every Gray bit above it.
   for (genvar i = 0; i < WIDTH; i++) begin : g_dec
      assign bin_dec[i] = ^g_q[WIDTH-1:i];
   end

   // bin_out only changes on valid stage-2 cycles, so it doubles as the previous value.
   assign delta   = bin_dec - bin_out;
   assign is_up   = locked && (delta == ONE);
   assign is_dn   = locked && (delta == '1);
   assign is_jump = locked && !(delta == ONE) && !(delta == '1) && (delta != '0);

   assign out_valid = vld_pipe[1];

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_pipe  <= '0;
         g_q       <= '0;
         bin_out   <= '0;
         step_up   <= 1'b0;
         step_down <= 1'b0;
         jump_err  <= 1'b0;
         locked    <= 1'b0;
         err_count <= '0;
      end else begin
         vld_pipe <= {vld_pipe[0], in_valid};
         if (in_valid) g_q <= gray_in;

         step_up   <= vld_pipe[0] && is_up;
         step_down <= vld_pipe[0] && is_dn;
         jump_err  <= vld_pipe[0] && is_jump;
         if (vld_pipe[0]) begin
            bin_out <= bin_dec;
            locked  <= 1'b1;
         end

         if (err_clr)
            err_count <= '0;
         else if (vld_pipe[0] && is_jump && (err_count != '1))
            err_count <= err_count + ERR_W'(1);
      end
   end

endmodule

// File: tb/tb_gray_to_binary_tracker.sv
// Randomized and directed bench for gray_to_binary_tracker with a cycle-level
// behavioural reference model (WIDTH=4, ERR_W=2 so saturation is reachable).
module tb_gray_to_binary_tracker;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] gray_in = '0;
   logic       in_valid = 1'b0;
   logic       err_clr = 1'b0;
   logic [3:0] bin_out;
   logic       out_valid, step_up, step_down, jump_err, locked;
   logic [1:0] err_count;

   gray_to_binary_tracker #(.WIDTH(4), .ERR_W(2)) dut (
      .clk(clk), .rst(rst), .gray_in(gray_in), .in_valid(in_valid), .err_clr(err_clr),
      .bin_out(bin_out), .out_valid(out_valid), .step_up(step_up), .step_down(step_down),
      .jump_err(jump_err), .locked(locked), .err_count(err_count)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // model state
   int   e_bin = 0, e_err = 0;
   logic e_ov = 0, e_up = 0, e_dn = 0, e_je = 0, m_locked = 0;
   logic h_v = 0, h_r = 1;
   logic [3:0] h_g = '0;

   logic [10:0] obs, expv;
   assign obs  = {out_valid, bin_out, step_up, step_down, jump_err, locked, err_count};
   assign expv = {e_ov, 4'(e_bin), e_up, e_dn, e_je, m_locked, 2'(e_err)};

   function automatic int g2b(input logic [3:0] g);
      int gi = int'(g);
      int b  = gi;
      for (int s = 1; s < 4; s++) b = b ^ (gi >> s);
      return b;
   endfunction

   function automatic logic [3:0] b2g(input int b);
      return 4'(b ^ (b >> 1));
   endfunction

   // Drive one cycle of inputs, advance the model at the edge, settle for sampling.
   task automatic tick(input logic [3:0] g, input logic v, input logic clr, input logic r);
      int nb, d;
      logic fire;
      gray_in = g; in_valid = v; err_clr = clr; rst = r;
      @(posedge clk);
      if (r) begin
         e_bin = 0; e_err = 0; e_ov = 0; e_up = 0; e_dn = 0; e_je = 0; m_locked = 0;
      end else begin
         fire = h_v && !h_r;
         e_ov = fire; e_up = 0; e_dn = 0; e_je = 0;
         if (fire) begin
            nb = g2b(h_g);
            if (m_locked) begin
               d = (nb - e_bin + 16) % 16;
               e_up = (d == 1);
               e_dn = (d == 15);
               e_je = (d > 1) && (d < 15);
            end
            e_bin = nb;
            m_locked = 1;
         end
         if (clr) e_err = 0;
         else if (e_je && e_err < 3) e_err = e_err + 1;
      end
      h_v = v; h_g = g; h_r = r;
      #1;
   endtask

   task automatic test_reset;
      tick(4'b0000, 0, 0, 1);
      tick(4'b0000, 0, 0, 1);
      total++;
      if (obs !== 11'd0) begin
         bad++; $display("FAIL reset_state got=%b want=%b", obs, 11'd0);
      end
      tick(4'b0111, 1, 0, 0);
      tick(4'b0000, 0, 0, 0);
      total++;
      if (obs !== expv || bin_out !== 4'd5 || !out_valid || !locked || step_up || step_down || jump_err) begin
         bad++; $display("FAIL first_sample got=%b want=%b", obs, expv);
      end
   endtask

   task automatic test_stepping;
      logic [3:0] seq [6] = '{4'b0111, 4'b0101, 4'b0111, 4'b0110, 4'b0000, 4'b0000};
      int nvalid = 0;
      tick(4'b0000, 0, 0, 1);
      for (int i = 0; i < 6; i++) begin
         tick(seq[i], i < 4, 0, 0);
         nvalid += int'(out_valid);
         total++;
         if (obs !== expv) begin
            bad++; $display("FAIL stepping[%0d] got=%b want=%b", i, obs, expv);
         end
      end
      total++;
      if (nvalid != 4) begin
         bad++; $display("FAIL stepping_valid_count got=%0d want=4", nvalid);
      end
   endtask

   task automatic test_wrap;
      logic [3:0] seq [5] = '{4'b1000, 4'b0000, 4'b1000, 4'b0000, 4'b0000};
      tick(4'b0000, 0, 0, 1);
      for (int i = 0; i < 5; i++) begin
         tick(seq[i], i < 3, 0, 0);
         total++;
         if (obs !== expv) begin
            bad++; $display("FAIL wrap[%0d] got=%b want=%b", i, obs, expv);
         end
      end
   endtask

   task automatic test_jump_sat;
      // 5,8 alternate: every sample after the first is an illegal jump
      tick(4'b0000, 0, 0, 1);
      for (int i = 0; i < 8; i++) begin
         tick((i % 2) ? 4'b1100 : 4'b0111, i < 6, 0, 0);
         total++;
         if (obs !== expv) begin
            bad++; $display("FAIL jump_sat[%0d] got=%b want=%b", i, obs, expv);
         end
      end
      total++;
      if (err_count !== 2'd3) begin
         bad++; $display("FAIL jump_saturate got=%0d want=3", err_count);
      end
      // one more jump (prev=8 -> 5) decided at the same edge as err_clr
      tick(4'b0111, 1, 0, 0);
      tick(4'b0000, 0, 1, 0);
      total++;
      if (obs !== expv || err_count !== 2'd0 || !jump_err) begin
         bad++; $display("FAIL clr_beats_jump got=%b want=%b", obs, expv);
      end
   endtask

   task automatic test_gap;
      logic [3:0] seq [7] = '{4'b0111, 4'b0000, 4'b0000, 4'b0000, 4'b0101, 4'b0000, 4'b0000};
      logic       vld [7] = '{1, 0, 0, 0, 1, 0, 0};
      int pulses = 0;
      tick(4'b0000, 0, 0, 1);
      for (int i = 0; i < 7; i++) begin
         tick(seq[i], vld[i], 0, 0);
         pulses += int'(out_valid);
         total++;
         if (obs !== expv) begin
            bad++; $display("FAIL gap[%0d] got=%b want=%b", i, obs, expv);
         end
      end
      total++;
      if (pulses != 2 || bin_out !== 4'd6) begin
         bad++; $display("FAIL gap_pulses got=%0d/%0d want=2/6", pulses, bin_out);
      end
   endtask

   task automatic test_reset_mid;
      logic [3:0] seq [6] = '{4'b0111, 4'b0101, 4'b1100, 4'b1101, 4'b0000, 4'b0000};
      logic       rr  [6] = '{0, 1, 0, 0, 0, 0};
      tick(4'b0000, 0, 0, 1);
      tick(4'b0110, 1, 0, 0);
      tick(4'b0110, 1, 0, 0);
      for (int i = 0; i < 6; i++) begin
         tick(seq[i], i < 4, 0, rr[i]);
         total++;
         if (obs !== expv) begin
            bad++; $display("FAIL reset_mid[%0d] got=%b want=%b", i, obs, expv);
         end
      end
   endtask

   task automatic test_random;
      int rb = 0;
      int pick;
      logic [3:0] g;
      for (int i = 0; i < 400; i++) begin
         pick = int'($urandom_range(0, 9));
         if (pick < 4) rb = (rb + 1) % 16;
         else if (pick < 7) rb = (rb + 15) % 16;
         else if (pick < 8) rb = rb;
         else rb = int'($urandom_range(0, 15));
         g = b2g(rb);
         tick(g, $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0, $urandom_range(0, 59) == 0);
         total++;
         if (obs !== expv) begin
            bad++; $display("FAIL random[%0d] got=%b want=%b", i, obs, expv);
         end
      end
   endtask

   initial begin
      test_reset;
      test_stepping;
      test_wrap;
      test_jump_sat;
      test_gap;
      test_reset_mid;
      test_random;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
